// File: rtl/dxc_bw_reconfig_seq.sv
// DXC bandwidth reconfiguration sequencer: IDLE -> ARMED (wait RFP) -> DRAIN -> HOLD_RST -> SETTLE.
// Optional drain watchdog enabled by defining DXC_CFG_DRAIN_WDOG_EN.
module dxc_bw_reconfig_seq #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned IDLE_GAP      = 4,
  parameter int unsigned DRAIN_TIMEOUT = 1024,
  parameter logic [7:0]  DEF_BW_CC1    = 8'h01,
  parameter logic [7:0]  DEF_BW_CC2    = 8'h01
) (
  input  logic       dsp_in_clk_clk,
  input  logic       dsp_in_reset_reset_n,
  input  logic       cfg_req_valid,
  input  logic [7:0] cfg_req_cc1,
  input  logic [7:0] cfg_req_cc2,
  input  logic       rfp_pulse_data,
  input  logic       dp_valid,
  output logic [7:0] bw_config_cc1,
  output logic [7:0] bw_config_cc2,
  output logic       soft_rst_n,
  output logic       cfg_busy,
  output logic       cfg_done,
  output logic       cfg_rejected,
  output logic       cfg_timeout,
  output logic [2:0] seq_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARMED    = 3'd1,
    S_DRAIN    = 3'd2,
    S_HOLD_RST = 3'd3,
    S_SETTLE   = 3'd4
  } state_e;

  localparam int unsigned RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned GW = $clog2(IDLE_GAP + 1);
  localparam logic [RW-1:0] RST_T = RW'(RST_CYCLES - 1);
  localparam logic [SW-1:0] SET_T = SW'(SETTLE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_T = GW'(IDLE_GAP);

  if (RST_CYCLES < 1 || SETTLE_CYCLES < 1 || IDLE_GAP < 1 || DRAIN_TIMEOUT < 1) begin : g_param_chk
    $error("dxc_bw_reconfig_seq: cycle parameters must be >= 1");
  end

  state_e        state_q, state_d;
  logic          init_q, init_d;
  logic [7:0]    req_cc1_q, req_cc1_d, req_cc2_q, req_cc2_d;
  logic [7:0]    bw1_q, bw1_d, bw2_q, bw2_d;
  logic          srst_n_q, srst_n_d, busy_q, busy_d;
  logic          done_q, done_d, rej_q, rej_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [SW-1:0] set_cnt_q, set_cnt_d;
  logic [GW-1:0] gap_q, gap_d, gap_inc;
  logic          enter_hold;

`ifdef DXC_CFG_DRAIN_WDOG_EN
  localparam int unsigned TW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [TW-1:0] TOUT_T = TW'(DRAIN_TIMEOUT);
  logic [TW-1:0] dwell_q, dwell_d, dwell_inc;
  logic          tout_q, tout_d;
`endif

  always_comb begin
    state_d    = state_q;
    init_d     = init_q;
    req_cc1_d  = req_cc1_q;
    req_cc2_d  = req_cc2_q;
    bw1_d      = bw1_q;
    bw2_d      = bw2_q;
    rst_cnt_d  = rst_cnt_q;
    set_cnt_d  = set_cnt_q;
    gap_d      = gap_q;
    gap_inc    = '0;
    enter_hold = 1'b0;
    done_d     = 1'b0;
    rej_d      = 1'b0;
`ifdef DXC_CFG_DRAIN_WDOG_EN
    dwell_d    = dwell_q;
    dwell_inc  = '0;
    tout_d     = tout_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cfg_req_valid) begin
          if (cfg_req_cc1 == bw1_q && cfg_req_cc2 == bw2_q) begin
            done_d = 1'b1;
          end else begin
            req_cc1_d = cfg_req_cc1;
            req_cc2_d = cfg_req_cc2;
            state_d   = S_ARMED;
`ifdef DXC_CFG_DRAIN_WDOG_EN
            tout_d    = 1'b0;
`endif
          end
        end
      end
      S_ARMED: begin
        if (rfp_pulse_data) begin
          state_d = S_DRAIN;
          gap_d   = '0;
`ifdef DXC_CFG_DRAIN_WDOG_EN
          dwell_d = '0;
`endif
        end
      end
      S_DRAIN: begin
        gap_inc = dp_valid ? '0 : ((gap_q == GAP_T) ? gap_q : gap_q + 1'b1);
        gap_d   = gap_inc;
        if (gap_inc == GAP_T) enter_hold = 1'b1;
`ifdef DXC_CFG_DRAIN_WDOG_EN
        // Gap completion takes priority over a coincident timeout.
        dwell_inc = (dwell_q == TOUT_T) ? dwell_q : dwell_q + 1'b1;
        dwell_d   = dwell_inc;
        if (!enter_hold && dwell_inc == TOUT_T) begin
          enter_hold = 1'b1;
          tout_d     = 1'b1;
        end
`endif
        if (enter_hold) begin
          state_d   = S_HOLD_RST;
          rst_cnt_d = '0;
          bw1_d     = req_cc1_q;
          bw2_d     = req_cc2_q;
        end
      end
      S_HOLD_RST: begin
        if (rst_cnt_q == RST_T) begin
          state_d   = S_SETTLE;
          set_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      S_SETTLE: begin
        if (set_cnt_q == SET_T) begin
          state_d = S_IDLE;
          done_d  = !init_q;
          init_d  = 1'b0;
        end else begin
          set_cnt_d = set_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (cfg_req_valid && state_q != S_IDLE) rej_d = 1'b1;
    srst_n_d = (state_d != S_HOLD_RST);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge dsp_in_clk_clk or negedge dsp_in_reset_reset_n) begin
    if (!dsp_in_reset_reset_n) begin
      state_q   <= S_HOLD_RST;
      init_q    <= 1'b1;
      req_cc1_q <= DEF_BW_CC1;
      req_cc2_q <= DEF_BW_CC2;
      bw1_q     <= DEF_BW_CC1;
      bw2_q     <= DEF_BW_CC2;
      srst_n_q  <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      rej_q     <= 1'b0;
      rst_cnt_q <= '0;
      set_cnt_q <= '0;
      gap_q     <= '0;
`ifdef DXC_CFG_DRAIN_WDOG_EN
      dwell_q   <= '0;
      tout_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      init_q    <= init_d;
      req_cc1_q <= req_cc1_d;
      req_cc2_q <= req_cc2_d;
      bw1_q     <= bw1_d;
      bw2_q     <= bw2_d;
      srst_n_q  <= srst_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rej_q     <= rej_d;
      rst_cnt_q <= rst_cnt_d;
      set_cnt_q <= set_cnt_d;
      gap_q     <= gap_d;
`ifdef DXC_CFG_DRAIN_WDOG_EN
      dwell_q   <= dwell_d;
      tout_q    <= tout_d;
`endif
    end
  end

  assign bw_config_cc1 = bw1_q;
  assign bw_config_cc2 = bw2_q;
  assign soft_rst_n    = srst_n_q;
  assign cfg_busy      = busy_q;
  assign cfg_done      = done_q;
  assign cfg_rejected  = rej_q;
  assign seq_state     = state_q;
`ifdef DXC_CFG_DRAIN_WDOG_EN
  assign cfg_timeout   = tout_q;
`else
  assign cfg_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_dxc_bw_reconfig_seq.sv
// Scoreboard bench for dxc_bw_reconfig_seq: expected state segments queued by stimulus, popped on each state change.
module tb_dxc_bw_reconfig_seq;
  localparam int unsigned RSTC = 16;
  localparam int unsigned SETC = 64;
  localparam int unsigned TOUT = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_v = 1'b0;
  logic [7:0] req_c1 = '0, req_c2 = '0;
  logic       rfp = 1'b0;
  logic       dpv = 1'b0;
  logic [7:0] bw1, bw2;
  logic       srst_n, busy, done, rej, tout;
  logic [2:0] st;

  always #5 clk = ~clk;

  dxc_bw_reconfig_seq #(
    .RST_CYCLES(RSTC), .SETTLE_CYCLES(SETC), .IDLE_GAP(4), .DRAIN_TIMEOUT(TOUT),
    .DEF_BW_CC1(8'h01), .DEF_BW_CC2(8'h01)
  ) dut (
    .dsp_in_clk_clk(clk), .dsp_in_reset_reset_n(rst_n),
    .cfg_req_valid(req_v), .cfg_req_cc1(req_c1), .cfg_req_cc2(req_c2),
    .rfp_pulse_data(rfp), .dp_valid(dpv),
    .bw_config_cc1(bw1), .bw_config_cc2(bw2), .soft_rst_n(srst_n),
    .cfg_busy(busy), .cfg_done(done), .cfg_rejected(rej), .cfg_timeout(tout),
    .seq_state(st)
  );

  typedef struct {
    logic [2:0]  st;
    int unsigned dur;   // 0: duration not predicted
    logic [15:0] bw;    // applied value seen in the first clock of the next state
    logic        done;  // cfg_done expected on SETTLE exit
  } seg_t;

  seg_t        exp_q[$];
  int unsigned n_chk = 0, n_err = 0;
  int unsigned exp_done = 0, exp_rej = 0;
  int unsigned done_cnt = 0, rej_cnt = 0;
  logic        mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Segment monitor
  logic [2:0]  cur_st = 3'd3;
  int unsigned seg_len = 0, lo_cnt = 0;
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (done) done_cnt++;
      if (rej) rej_cnt++;
      if (st != cur_st) begin
        if (exp_q.size() == 0) begin
          chk("extra_seg", {29'b0, st}, {29'b0, cur_st});
        end else begin
          seg_t e;
          e = exp_q.pop_front();
          chk("seg_state", {29'b0, cur_st}, {29'b0, e.st});
          if (e.dur != 0) chk("seg_dur", seg_len, e.dur);
          chk("seg_srst_lo", lo_cnt, (e.st == 3'd3) ? e.dur : 0);
          chk("seg_bw", {16'b0, bw1, bw2}, {16'b0, e.bw});
          if (e.st == 3'd4) chk("seg_done", {31'b0, done}, {31'b0, e.done});
          chk("seg_busy", {31'b0, busy}, {31'b0, (st != 3'd0)});
        end
        cur_st  = st;
        seg_len = 1;
        lo_cnt  = srst_n ? 0 : 1;
      end else begin
        seg_len++;
        if (!srst_n) lo_cnt++;
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [15:0] old_bw, input logic [15:0] new_bw,
                          input int unsigned armed, input int unsigned drain);
    exp_q.push_back('{3'd0, 0, old_bw, 1'b0});
    exp_q.push_back('{3'd1, armed, old_bw, 1'b0});
    exp_q.push_back('{3'd2, drain, new_bw, 1'b0});
    exp_q.push_back('{3'd3, RSTC, new_bw, 1'b0});
    exp_q.push_back('{3'd4, SETC, new_bw, 1'b1});
    exp_done++;
  endtask

  // Request pulse; returns just after the sampling edge.
  task automatic do_req(input logic [7:0] c1, input logic [7:0] c2, input logic with_rfp);
    tick(0);
    @(posedge clk); #1;
    req_v = 1'b1; req_c1 = c1; req_c2 = c2; rfp = with_rfp;
    tick(1);
    req_v = 1'b0; rfp = 1'b0;
  endtask

  task automatic rfp_after(input int unsigned n);
    tick(n - 1);
    rfp = 1'b1;
    tick(1);
    rfp = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int unsigned budget);
    int unsigned i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (st == 3'd0 && !busy) break;
    end
    if (i == budget) chk(tag, {29'b0, st}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [7:0] pat;
    pat = 8'b0000_1000;  // dp_valid sequence 0,0,0,1,0,0,0,0 (bit i = clock i)

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_bw", {16'b0, bw1, bw2}, 32'h0101);
    chk("rst_srst", {31'b0, srst_n}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd1);
    chk("rst_flags", {29'b0, done, rej, tout}, 32'd0);
    chk("rst_state", {29'b0, st}, 32'd3);

    // Init sequence, no cfg_done
    exp_q.push_back('{3'd3, RSTC, 16'h0101, 1'b0});
    exp_q.push_back('{3'd4, SETC, 16'h0101, 1'b0});
    @(posedge clk); #1;
    rst_n = 1'b1; mon_en = 1'b1;
    wait_idle("init_idle_wait", 200);
    tick(2);
    chk("init_no_done", done_cnt, 0);
    chk("init_bw", {16'b0, bw1, bw2}, 32'h0101);

    // Same-value request: immediate done, no reset
    do_req(8'h01, 8'h01, 1'b0);
    exp_done++;
    chk("same_done", {31'b0, done}, 32'd1);
    chk("same_state", {29'b0, st}, 32'd0);
    chk("same_srst", {31'b0, srst_n}, 32'd1);
    tick(1);
    chk("same_done_end", {31'b0, done}, 32'd0);

    // Basic sequence 04/02, rfp 10 clocks after acceptance
    push_seq(16'h0101, 16'h0402, 10, 4);
    dpv = 1'b0;
    do_req(8'h04, 8'h02, 1'b0);
    rfp_after(10);
    wait_idle("basic_idle_wait", 300);

    // rfp coincident with acceptance is ignored; gap restart; rejection during SETTLE
    push_seq(16'h0402, 16'h0310, 6, 8);
    dpv = 1'b1;
    do_req(8'h03, 8'h10, 1'b1);
    rfp_after(6);
    for (int i = 0; i < 8; i++) begin
      dpv = pat[i];
      tick(1);
    end
    dpv = 1'b0;
    tick(RSTC + 5);
    do_req(8'h55, 8'h66, 1'b0);
    exp_rej++;
    chk("rej_bw", {16'b0, bw1, bw2}, 32'h0310);
    wait_idle("restart_idle_wait", 300);

    // Long DRAIN with dp_valid held high
`ifdef DXC_CFG_DRAIN_WDOG_EN
    push_seq(16'h0310, 16'h0a0b, 10, TOUT);
    dpv = 1'b1;
    do_req(8'h0a, 8'h0b, 1'b0);
    rfp_after(10);
    wait_idle("wdog_idle_wait", 2000);
    dpv = 1'b0;
    chk("wdog_tout_set", {31'b0, tout}, 32'd1);
    tick(5);
    chk("wdog_tout_held", {31'b0, tout}, 32'd1);
    push_seq(16'h0a0b, 16'h0c0d, 10, 4);
    do_req(8'h0c, 8'h0d, 1'b0);
    chk("wdog_tout_clr", {31'b0, tout}, 32'd0);
    rfp_after(10);
    wait_idle("wdog2_idle_wait", 300);
`else
    push_seq(16'h0310, 16'h0a0b, 10, 1100 + 4);
    dpv = 1'b1;
    do_req(8'h0a, 8'h0b, 1'b0);
    rfp_after(10);
    tick(1100);
    chk("nowdog_state", {29'b0, st}, 32'd2);
    chk("nowdog_tout", {31'b0, tout}, 32'd0);
    dpv = 1'b0;
    wait_idle("long_idle_wait", 300);
`endif

    tick(4);
    chk("done_total", done_cnt, exp_done);
    chk("rej_total", rej_cnt, exp_rej);
    chk("segq_left", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
